// File: rtl/max_pool2x2_pkg.sv
// Shared word geometry for the pooling stage.
// 16 unsigned 8-bit lanes packed into one 128-bit word.
package max_pool2x2_pkg;

  localparam int WORD_SIZE = 128;
  localparam int DATA_SIZE = 8;
  localparam int LANES     = WORD_SIZE / DATA_SIZE;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [DATA_SIZE-1:0] lane_t;

endpackage

// File: rtl/max_pool2x2_max_lane16.sv
// Combinational lane-wise unsigned maximum of two words.
// Used for both the horizontal and vertical pooling steps.
module max_lane16
  import max_pool2x2_pkg::*;
(
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] y
);

  lane_t la;
  lane_t lb;

  always_comb begin
    y  = '0;
    la = '0;
    lb = '0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*DATA_SIZE +: DATA_SIZE];
      lb = b[i*DATA_SIZE +: DATA_SIZE];
      y[i*DATA_SIZE +: DATA_SIZE] = (la > lb) ? la : lb;
    end
  end

endmodule

// File: rtl/max_pool2x2.sv
// 2x2 stride-2 max-pool over a raster stream of 16-lane words.
// Optional POOL_LAST_EN adds a row counter and the DO_last flag.
module max_pool2x2
  import max_pool2x2_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int BUF_AW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DI_valid,
  input  logic [WORD_SIZE-1:0] DI,
  output logic                 DO_valid,
  output logic [WORD_SIZE-1:0] DO
`ifdef POOL_LAST_EN
  ,
  output logic                 DO_last
`endif
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  if ((IMG_W % 2) != 0 || IMG_W < 2 ||
      (IMG_H % 2) != 0 || IMG_H < 2 ||
      (2 ** BUF_AW) < (IMG_W / 2)) begin : g_bad_cfg
    $error("max_pool2x2: bad geometry");
  end

  logic [CW-1:0]     col;
  logic              par;
  word_t             hold;
  word_t             linebuf [2**BUF_AW];
  logic [BUF_AW-1:0] addr;
  word_t             lb_rd;
  word_t             hmax;
  word_t             vmax;
  logic              col_wrap;

  assign addr     = BUF_AW'(col >> 1);
  assign lb_rd    = linebuf[addr];
  assign col_wrap = (col == COL_LAST);

  max_lane16 u_hmax (
    .a (hold),
    .b (DI),
    .y (hmax)
  );

  max_lane16 u_vmax (
    .a (hmax),
    .b (lb_rd),
    .y (vmax)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      col      <= '0;
      par      <= 1'b0;
      hold     <= '0;
      DO       <= '0;
      DO_valid <= 1'b0;
    end else begin
      DO_valid <= 1'b0;
      if (DI_valid) begin
        col <= col_wrap ? '0 : col + CW'(1);
        if (col_wrap)
          par <= ~par;
        if (!col[0]) begin
          hold <= DI;
        end else if (par) begin
          DO       <= vmax;
          DO_valid <= 1'b1;
        end
      end
    end
  end

  // Even rows park the horizontal max; odd rows only read it back.
  always_ff @(posedge clk) begin
    if (rst && DI_valid && col[0] && !par)
      linebuf[addr] <= hmax;
  end

`ifdef POOL_LAST_EN
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [RW-1:0] row;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row     <= '0;
      DO_last <= 1'b0;
    end else begin
      DO_last <= 1'b0;
      if (DI_valid) begin
        if (col_wrap)
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        if (col_wrap && row == ROW_LAST)
          DO_last <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_max_pool2x2.sv
// Scoreboard bench for max_pool2x2 (IMG_W=4, IMG_H=4).
// Reference model pools a stored image window with plain arithmetic.
module tb_max_pool2x2;
  import max_pool2x2_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    word_t d;
    logic  last;
    int    cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  DI_valid = 1'b0;
  word_t DI = '0;
  logic  DO_valid;
  word_t DO;
`ifdef POOL_LAST_EN
  logic  DO_last;
`endif

  int    total = 0;
  int    bad   = 0;
  int    ncyc  = 0;
  exp_t  q[$];
  word_t img [2][W];
  int    m_col = 0;
  int    m_row = 0;

  always #5 clk = ~clk;

  max_pool2x2 #(
    .IMG_W  (W),
    .IMG_H  (H),
    .BUF_AW (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DI_valid (DI_valid),
    .DI       (DI),
    .DO_valid (DO_valid),
    .DO       (DO)
`ifdef POOL_LAST_EN
    ,
    .DO_last  (DO_last)
`endif
  );

  function automatic word_t fill(input int v);
    word_t r;
    for (int l = 0; l < LANES; l++)
      r[l*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic word_t rnd_word();
    word_t r;
    for (int k = 0; k < 4; k++)
      r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic word_t max4(input word_t a, input word_t b,
                                 input word_t c, input word_t d);
    word_t r;
    word_t w[4];
    int    m;
    w = '{a, b, c, d};
    for (int l = 0; l < LANES; l++) begin
      m = 0;
      for (int k = 0; k < 4; k++)
        if (int'(w[k][l*8 +: 8]) > m)
          m = int'(w[k][l*8 +: 8]);
      r[l*8 +: 8] = 8'(m);
    end
    return r;
  endfunction

  task automatic model(input word_t d);
    exp_t e;
    img[m_row % 2][m_col] = d;
    if ((m_row % 2) == 1 && (m_col % 2) == 1) begin
      e.d = max4(img[0][m_col-1], img[0][m_col],
                 img[1][m_col-1], img[1][m_col]);
      e.last = (m_row == H-1) && (m_col == W-1);
      e.cyc = ncyc;
      q.push_back(e);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row + 1) % H;
    end
  endtask

  task automatic beat(input logic v, input word_t d);
    DI_valid = v;
    DI = d;
    @(posedge clk);
    if (v && rst)
      model(d);
    #1;
  endtask

  task automatic gap_beat(input word_t d);
    while ($urandom_range(1, 0) == 1)
      beat(1'b0, rnd_word());
    beat(1'b1, d);
  endtask

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (DO_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_valid got DO=%h want no pulse", DO);
      end else begin
        e = q.pop_front();
        if (DO !== e.d) begin
          bad++;
          $display("FAIL do_data got=%h want=%h", DO, e.d);
        end
        total++;
        if (ncyc != e.cyc + 1) begin
          bad++;
          $display("FAIL latency got=%0d want=%0d", ncyc, e.cyc + 1);
        end
`ifdef POOL_LAST_EN
        total++;
        if (DO_last !== e.last) begin
          bad++;
          $display("FAIL do_last got=%b want=%b", DO_last, e.last);
        end
`endif
      end
    end else begin
`ifdef POOL_LAST_EN
      total++;
      if (DO_last !== 1'b0) begin
        bad++;
        $display("FAIL do_last_idle got=%b want=0", DO_last);
      end
`endif
      if (q.size() > 0 && ncyc > q[0].cyc + 1) begin
        total++;
        bad++;
        $display("FAIL missing_valid got=0 want=1 (exp %h)", q[0].d);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    word_t ex;

    // reset held with DI_valid high
    beat(1'b1, rnd_word());
    beat(1'b1, rnd_word());
    @(negedge clk);
    chk("rst_do", DO, '0);
    chk("rst_valid", word_t'(DO_valid), '0);
    #1;
    rst = 1'b1;

    // two rows of scalar-filled pixels
    for (int v = 1; v <= 8; v++)
      beat(1'b1, fill(v));
    beat(1'b0, '0);
    beat(1'b0, '0);
    chk("t2_hold", DO, fill(8'h08));

    // lane independence window
    for (int p = 0; p < 4; p++) begin
      ex = '0;
      for (int l = 0; l < LANES; l++)
        ex[l*8 +: 8] = (p % 2 == 0) ? 8'(l) : 8'(8'h7F - l);
      beat(1'b1, ex);
    end
    for (int p = 0; p < 4; p++)
      beat(1'b1, (p % 2 == 0) ? fill(0) : fill(8'h10));
    beat(1'b0, '0);
    beat(1'b0, '0);
    for (int l = 0; l < LANES; l++)
      ex[l*8 +: 8] = 8'(8'h7F - l);
    chk("t3_lanes", DO, ex);

    // gapped replay of scalar rows
    for (int v = 1; v <= 8; v++)
      gap_beat(fill(v));
    beat(1'b0, '0);
    beat(1'b0, '0);
    chk("t4_hold", DO, fill(8'h08));

    // reset after 3rd beat of an odd row
    for (int p = 0; p < W + 3; p++)
      beat(1'b1, rnd_word());
    beat(1'b0, '0);
    beat(1'b0, '0);
    rst = 1'b0;
    m_col = 0;
    m_row = 0;
    beat(1'b1, rnd_word());
    beat(1'b1, rnd_word());
    @(negedge clk);
    chk("t5_rst_do", DO, '0);
    #1;
    rst = 1'b1;

    // two back-to-back random frames with gaps
    for (int p = 0; p < 2 * W * H; p++)
      gap_beat(rnd_word());
    for (int p = 0; p < 4; p++)
      beat(1'b0, rnd_word());

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
